// File: rtl/byte_lane_arbiter_if.sv
// ---------------------------------------------------------------------------
// byte_lane_arbiter_if
// Bundles the requester side and the serialized byte-lane side of the
// byte_lane_arbiter into one interface.
//
// Signals:
//   req       [N_REQ]    per-source request, held until the matching gnt
//   data_req  [32*N_REQ] flattened source words, word i at [32*i+31:32*i]
//   gnt       [N_REQ]    one-hot, single-cycle capture acknowledge
//   data_out  [8]        serialized byte, MSB of the word first
//   valid_out            data_out carries a word byte
//   slot      [2]        current byte slot 0..3
//   src_id    [3]        source owning the current frame, 0 when idle
//
// Modports:
//   master : requester side (drives req/data_req, observes the lane)
//   slave  : arbiter side   (receives req/data_req, drives the lane)
// ---------------------------------------------------------------------------
interface byte_lane_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] data_req;
  logic [N_REQ-1:0]    gnt;
  logic [7:0]          data_out;
  logic                valid_out;
  logic [1:0]          slot;
  logic [2:0]          src_id;

  modport master (
    output req, data_req,
    input  gnt, data_out, valid_out, slot, src_id
  );

  modport slave (
    input  req, data_req,
    output gnt, data_out, valid_out, slot, src_id
  );
endinterface

// File: rtl/byte_lane_arbiter.sv
// ---------------------------------------------------------------------------
// byte_lane_arbiter
// Round-robin arbiter and serializer sharing one 8-bit byte lane between
// N_REQ sources of 32-bit words. A free-running 4-cycle slot counter frames
// the lane; arbitration happens only on the slot-3 edge, and the winning
// word is shifted out MSB first on slots 0..3 of the following frame.
//
// Parameters:
//   N_REQ     number of requesters (2..8)
//   IDLE_BYTE byte driven on data_out while idle when IDLE_FILL_EN is set
//
// Ports:
//   clk_4f  byte-rate clock
//   reset   asynchronous, active-high reset
//   bus     byte_lane_arbiter_if.slave (req, data_req, gnt, data_out,
//           valid_out, slot, src_id)
//
// Build option:
//   IDLE_FILL_EN  when defined, data_out drives IDLE_BYTE while idle
//                 (from the first edge after reset); otherwise 8'h00.
// ---------------------------------------------------------------------------
module byte_lane_arbiter #(
  parameter int         N_REQ     = 4,
  parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  byte_lane_arbiter_if.slave    bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

`ifdef IDLE_FILL_EN
  localparam logic [7:0] IDLE_VAL = IDLE_BYTE;
`else
  // Fill disabled: the idle lane is always zero.
  localparam logic [7:0] IDLE_VAL = IDLE_BYTE & 8'h00;
`endif

  logic [1:0]       slot_q;
  logic [0:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [31:0]      shift_q, shift_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       src_q, src_d;
  logic             fill_q;

  // Round-robin search result
  logic             found;
  logic [2:0]       win_idx;
  logic [31:0]      win_word;
  logic [N_REQ-1:0] win_onehot;
  int               cand;

  // Scan p, p+1, ... modulo N_REQ; the first asserted request wins.
  always_comb begin
    found      = 1'b0;
    win_idx    = 3'd0;
    win_word   = 32'h0;
    win_onehot = '0;
    cand       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && bus.req[cand]) begin
        found            = 1'b1;
        win_idx          = 3'(cand);
        win_word         = bus.data_req[32*cand +: 32];
        win_onehot[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    shift_d = {shift_q[23:0], 8'h00};
    gnt_d   = '0;
    src_d   = src_q;
    if (slot_q == 2'd3) begin
      if (found) begin
        state_d = ST_SEND;
        ptr_d   = (win_idx == LAST_IDX) ? 3'd0 : win_idx + 3'd1;
        shift_d = win_word;
        gnt_d   = win_onehot;
        src_d   = win_idx;
      end else begin
        // No requester: go idle, pointer keeps its position.
        state_d = ST_IDLE;
        shift_d = 32'h0;
        src_d   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      slot_q  <= 2'd0;
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      shift_q <= 32'h0;
      gnt_q   <= '0;
      src_q   <= 3'd0;
      fill_q  <= 1'b0;
    end else begin
      slot_q  <= slot_q + 2'd1;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      shift_q <= shift_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      // Keeps data_out at zero during reset; the idle fill starts on the
      // first edge after release.
      fill_q  <= 1'b1;
    end
  end

  assign bus.slot      = slot_q;
  assign bus.gnt       = gnt_q;
  assign bus.src_id    = src_q;
  assign bus.valid_out = (state_q == ST_SEND);
  assign bus.data_out  = (state_q == ST_SEND) ? shift_q[31:24]
                       : (fill_q ? IDLE_VAL : 8'h00);

endmodule

// File: tb/tb_byte_lane_arbiter.sv
module tb_byte_lane_arbiter;

  localparam int N = 4;
`ifdef IDLE_FILL_EN
  localparam logic [7:0] IDLE_EXP = 8'hBC;
`else
  localparam logic [7:0] IDLE_EXP = 8'h00;
`endif

  logic clk_4f;
  logic reset;

  byte_lane_arbiter_if #(.N_REQ(N)) bif ();

  byte_lane_arbiter #(.N_REQ(N), .IDLE_BYTE(8'hBC)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bif.slave)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the lane.
  int          m_slot;
  int          m_ptr;
  int          m_src;
  bit          m_busy;
  bit          m_gnt;
  bit          m_fill;
  logic [31:0] m_word;

  task automatic model_reset();
    m_slot = 0; m_ptr = 0; m_src = 0;
    m_busy = 0; m_gnt = 0; m_fill = 0; m_word = 0;
  endtask

  // One clk_4f edge, using the request inputs present at that edge.
  task automatic model_edge();
    m_gnt = 0;
    if (m_slot == 3) begin
      bit found = 0;
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (!found && bif.req[c]) begin
          found  = 1;
          m_src  = c;
          m_word = bif.data_req[32*c +: 32];
        end
      end
      m_busy = found;
      m_gnt  = found;
      if (found) m_ptr = (m_src + 1) % N;
    end
    m_fill = 1;
    m_slot = (m_slot + 1) % 4;
  endtask

  task automatic check_outputs();
    logic [7:0] exp_data;
    exp_data = m_busy ? 8'((m_word >> (8 * (3 - m_slot))) & 32'hFF)
                      : (m_fill ? IDLE_EXP : 8'h00);
    chk("slot",  32'(bif.slot),      32'(m_slot));
    chk("valid", 32'(bif.valid_out), 32'(m_busy));
    chk("src",   32'(bif.src_id),    m_busy ? 32'(m_src) : 32'd0);
    chk("gnt",   32'(bif.gnt),       m_gnt ? (32'd1 << m_src) : 32'd0);
    chk("data",  32'(bif.data_out),  32'(exp_data));
  endtask

  task automatic step();
    @(posedge clk_4f);
    model_edge();
    @(negedge clk_4f);
    check_outputs();
  endtask

  // Random requester behaviour honouring the handshake rules.
  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (bif.req[i]) begin
        if (m_gnt && m_src == i && $urandom_range(1, 0) == 1) bif.req[i] = 1'b0;
        else if (!(m_gnt && m_src == i) && $urandom_range(99, 0) < 3) bif.req[i] = 1'b0;
      end else if ($urandom_range(99, 0) < 30) begin
        bif.data_req[32*i +: 32] = $urandom();
        bif.req[i] = 1'b1;
      end
    end
  endtask

  task automatic drop_on_gnt();
    if (m_gnt) bif.req[m_src] = 1'b0;
  endtask

  initial begin
    bit hit;
    reset = 1'b1;
    bif.req = '0;
    bif.data_req = '0;
    model_reset();
    repeat (3) @(posedge clk_4f);
    @(negedge clk_4f);
    chk("rst_slot",  32'(bif.slot),      32'd0);
    chk("rst_gnt",   32'(bif.gnt),       32'd0);
    chk("rst_data",  32'(bif.data_out),  32'd0);
    chk("rst_valid", 32'(bif.valid_out), 32'd0);
    chk("rst_src",   32'(bif.src_id),    32'd0);
    reset = 1'b0;

    // Single source
    bif.data_req[31:0] = 32'hA1B2C3D4;
    bif.req[0] = 1'b1;
    for (int n = 0; n < 10; n++) begin step(); drop_on_gnt(); end

    // All sources held: back-to-back frames in order
    bif.data_req = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    bif.req = '1;
    for (int n = 0; n < 24; n++) step();

    // Two sources held: fairness between 0 and 1
    bif.req = 4'b0011;
    for (int n = 0; n < 16; n++) step();

    // Idle period
    bif.req = '0;
    for (int n = 0; n < 8; n++) step();

    // Late request rising at slot 1
    hit = 0;
    for (int n = 0; n < 8 && !hit; n++) begin
      step();
      if (m_slot == 1) hit = 1;
    end
    chk("late_wait", 32'(hit), 32'd1);
    bif.data_req[64 +: 32] = 32'hCAFEF00D;
    bif.req[2] = 1'b1;
    for (int n = 0; n < 12; n++) begin step(); drop_on_gnt(); end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin step(); drive_random(); end

    // Reset during slot 2 of a frame
    bif.req = '0;
    bif.req[1] = 1'b1;
    hit = 0;
    for (int n = 0; n < 16 && !hit; n++) begin
      step();
      if (m_busy && m_slot == 2) hit = 1;
    end
    chk("rst_wait", 32'(hit), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_slot",  32'(bif.slot),      32'd0);
    chk("mid_gnt",   32'(bif.gnt),       32'd0);
    chk("mid_data",  32'(bif.data_out),  32'd0);
    chk("mid_valid", 32'(bif.valid_out), 32'd0);
    chk("mid_src",   32'(bif.src_id),    32'd0);
    model_reset();
    bif.req = '1;
    @(negedge clk_4f);
    reset = 1'b0;
    for (int n = 0; n < 20; n++) step();

    // More randomized traffic after reset
    bif.req = '0;
    for (int n = 0; n < 300; n++) begin step(); drive_random(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_lane_arbiter.md
Name: byte_lane_arbiter

Overview:
- Round-robin arbiter and serializer that shares one 8-bit byte lane between N_REQ word sources, each presenting 32-bit words.
- Grants one source per frame and emits its word as 4 consecutive bytes, MSB first.
- Frames align to a free-running 4-cycle slot counter, so each word lands on one clk_f period of the downstream 8->32 gather stage.
- Sits upstream of that stage and sequences which source owns the lane.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- IDLE_BYTE, 8'hBC, byte driven on data_out while idle (used only with IDLE_FILL_EN).

Ports:
- clk_4f  input  1  byte-rate clock, single clock domain.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-source request; held high until the matching gnt.
- data_req  input  32*N_REQ  flattened words; source i occupies bits [32*i+31:32*i]; must be stable while req[i]=1.
- gnt  output  N_REQ  one-hot, one-cycle pulse; the word was captured.
- data_out  output  8  serialized byte.
- valid_out  output  1  data_out carries a word byte.
- slot  output  2  current byte slot 0..3; slot 0 carries the MSB.
- src_id  output  3  index of the source owning the current frame; 0 when idle.

Behaviour:
- Reset (async): all outputs clear: slot=0, gnt=0, data_out=8'h00, valid_out=0, src_id=0. Round-robin pointer=0, shift register=0, state=IDLE.
- Slot counter: advances every clk_4f edge after reset (0,1,2,3,0,...), wraps 3->0, never stalls.
- Arbitration happens only on the edge where slot==3.
  - The search starts at pointer p and proceeds p, p+1, ..., wrapping modulo N_REQ. The first i with req[i]=1 wins.
  - On a win: capture data_req word i, set gnt[i]=1 for exactly the next cycle, set src_id=i, set p=(i+1) mod N_REQ, state=SEND.
  - On no request: state=IDLE and p is unchanged.
- SEND timing: bytes appear on the cycles with slot=0,1,2,3 as word[31:24], [23:16], [15:8], [7:0]. valid_out=1 on all four cycles.
  - gnt is coincident with the slot-0 byte.
  - Latency: req sampled at the slot-3 edge -> MSB on data_out the next cycle.
- Back-to-back: a new arbitration at the slot-3 edge that ends a frame starts the next frame with no bubble. valid_out stays 1.
- IDLE: valid_out=0, src_id=0, data_out=8'h00 (see Optional Feature).
- A req rising mid-frame waits for the next slot-3 edge. There is no preemption.
- A req dropped before its grant is simply not considered. A source must not drop req mid-frame; the word is already latched, so this has no effect.
- Simultaneous requests: exactly one gnt bit per frame. A source with req held continuously is served at least once every N_REQ frames.
- Reset mid-frame: the word is dropped, its gnt is not reissued, and the slot restarts at 0.
- The internal shift register shifts left by 8 per cycle. data_out = shift[31:24].

Optional Feature:
- Macro IDLE_FILL_EN.
  - Defined: data_out drives IDLE_BYTE while in IDLE, with valid_out still 0.
  - Undefined: data_out=8'h00 while in IDLE.
- Reset value of data_out is 8'h00 in both builds. The fill begins on the first cycle after reset deassertion.

Test Plan:
- Single source: req[0]=1, data_req[31:0]=32'hA1B2C3D4 -> at the next slot-3 edge gnt=4'b0001 for one cycle. data_out = A1,B2,C3,D4 on slots 0..3, valid_out=1, src_id=0.
- All four sources held high with words 11111111, 22222222, 33333333, 44444444 -> frames are granted in order 0,1,2,3,0 with no idle cycle between them and valid_out continuously 1.
- Round-robin fairness: after source 1 is granted, req=4'b0011 -> the next grant is source 0, then source 1.
- Late request: req[2] rises when slot=1 -> no gnt until the slot-3 edge; the first byte appears at slot 0 of the following frame.
- Reset asserted during slot 2 of a frame -> all outputs are 0 immediately. After release, slot restarts at 0 and arbitration resumes with pointer 0.
- With IDLE_FILL_EN and no req -> data_out=8'hBC, valid_out=0. Without the macro -> data_out=8'h00.
